// File: rtl/dlpc300_pkg.sv
// Shared types and constants for the DLPC300 power-up configuration sequencer.
package dlpc300_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWR_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_WR_REQ   = 4'd3,
    ST_WR_WAIT  = 4'd4,
    ST_RD_REQ   = 4'd5,
    ST_RD_WAIT  = 4'd6,
    ST_CHECK    = 4'd7,
    ST_GAP      = 4'd8,
    ST_DONE     = 4'd9,
    ST_FAIL     = 4'd10
  } seq_state_e;

  localparam int ENTRY_W   = 40;
  localparam int ADDR_MSB  = 39;
  localparam int ADDR_LSB  = 32;
  localparam int DATA_MSB  = 31;
  localparam int ROM_DEPTH = 16;
  localparam int CNT_MIN_W = 18;

  // Unpopulated ROM slots read back as a write of zero to address 0.
  localparam logic [ENTRY_W-1:0] ROM_DEFAULT_ENTRY = 40'h00_0000_0000;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/dlpc300_init_rom.sv
// Power-up register table for the DLPC300: {address, data} per entry, one-cycle read latency.
module dlpc300_init_rom
  import dlpc300_pkg::*;
(
  input  logic               clk,
  input  logic [7:0]         addr,
  output logic [ENTRY_W-1:0] entry
);

  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] entry_q;

  always_comb begin
    case (addr)
      8'd0:    entry_d = {8'h00, 32'h0000_0001};
      8'd1:    entry_d = {8'h04, 32'h1234_5678};
      8'd2:    entry_d = {8'h08, 32'hA5A5_5A5A};
      8'd3:    entry_d = {8'h0C, 32'h0000_00FF};
      8'd4:    entry_d = {8'h10, 32'h8000_0000};
      8'd5:    entry_d = {8'h14, 32'h0001_0002};
      8'd6:    entry_d = {8'h18, 32'hCAFE_F00D};
      8'd7:    entry_d = {8'h1C, 32'h0F0F_0F0F};
      8'd8:    entry_d = {8'h20, 32'h0000_0100};
      8'd9:    entry_d = {8'h24, 32'hFFFF_0000};
      8'd10:   entry_d = {8'h28, 32'h0000_0003};
      8'd11:   entry_d = {8'h2C, 32'h1357_9BDF};
      8'd12:   entry_d = {8'h30, 32'h2468_ACE0};
      8'd13:   entry_d = {8'h34, 32'h0000_0040};
      8'd14:   entry_d = {8'h38, 32'h7FFF_FFFF};
      8'd15:   entry_d = {8'h3C, 32'h0000_0000};
      default: entry_d = ROM_DEFAULT_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/dlpc300_init_seq.sv
// Walks the init ROM after power-up, writing each entry to the DLPC300 config port
// with optional read-back verify, bounded retries and a fixed inter-transaction gap.
//
// state    | meaning
// IDLE     | port idle, waiting for start
// PWR_WAIT | power-up settle delay
// FETCH    | ROM read of current index
// WR_REQ   | latch address/data, raise write request
// WR_WAIT  | wait for write STOP or timeout
// RD_REQ   | raise read-back request
// RD_WAIT  | capture read data, wait for STOP or timeout
// CHECK    | compare read-back with written data
// GAP      | idle spacing before next transaction
// DONE     | one-cycle completion pulse
// FAIL     | entry exhausted its retries; error set
module dlpc300_init_seq
  import dlpc300_pkg::*;
#(
  parameter int N_ENTRIES      = 16,
  parameter int PWR_DELAY      = 100000,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRY      = 2,
  parameter int VERIFY         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic [7:0]  dlpc_address,
  output logic        dlpc_wr_req,
  output logic [31:0] dlpc_wr_data,
  output logic        dlpc_rd_req,
  input  logic [31:0] dlpc_rd_data,
  input  logic        dlpc_rd_valid,
  output logic        dlpc_rd_ready,
  input  logic        xfer_done
);

  localparam int CNT_W = cnt_width(PWR_DELAY, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PWR_LAST = (PWR_DELAY > 0)      ? CNT_W'(PWR_DELAY - 1)      : '0;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0)     ? CNT_W'(GAP_CYCLES - 1)     : '0;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [7:0] LAST_INDEX = 8'(N_ENTRIES - 1);
  localparam logic [7:0] RETRY_MAX  = 8'(MAX_RETRY);

  seq_state_e         state_d, state_q;
  logic [7:0]         index_d, index_q;
  logic [7:0]         retry_d, retry_q;
  logic               redo_d, redo_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [31:0]        rd_cap_d, rd_cap_q;
  logic               rd_seen_d, rd_seen_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               error_d, error_q;
  logic [7:0]         err_index_d, err_index_q;
  logic [7:0]         addr_d, addr_q;
  logic [31:0]        wr_data_d, wr_data_q;
  logic               wr_req_d, wr_req_q;
  logic               rd_req_d, rd_req_q;
  logic               retry_hit;
  logic [ENTRY_W-1:0] rom_entry;

  dlpc300_init_rom u_rom (
    .clk   (clk),
    .addr  (index_q),
    .entry (rom_entry)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    redo_d      = redo_q;
    cnt_d       = cnt_q;
    rd_cap_d    = rd_cap_q;
    rd_seen_d   = rd_seen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_index_d = err_index_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_req_d    = 1'b0;
    rd_req_d    = 1'b0;
    retry_hit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_PWR_WAIT;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          err_index_d = '0;
          index_d     = '0;
          retry_d     = '0;
          redo_d      = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FETCH: state_d = ST_WR_REQ;
      ST_WR_REQ: begin
        addr_d    = rom_entry[ADDR_MSB:ADDR_LSB];
        wr_data_d = rom_entry[DATA_MSB:0];
        wr_req_d  = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (xfer_done) begin
          cnt_d   = '0;
          state_d = (VERIFY != 0) ? ST_RD_REQ : ST_GAP;
        end else if (cnt_q == TMO_LAST) begin
          retry_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_REQ: begin
        rd_req_d  = 1'b1;
        rd_seen_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (dlpc_rd_valid && dlpc_rd_ready) begin
          rd_cap_d  = dlpc_rd_data;
          rd_seen_d = 1'b1;
        end
        if (xfer_done) begin
          state_d = ST_CHECK;
        end else if (cnt_q == TMO_LAST) begin
          retry_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (rd_seen_q && (rd_cap_q == wr_data_q)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          retry_hit = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (redo_q) begin
            redo_d  = 1'b0;
            state_d = ST_FETCH;
          end else if (index_q == LAST_INDEX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 8'd1;
            retry_d = '0;
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (retry_hit) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 8'd1;
        redo_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_GAP;
      end else begin
        err_index_d = index_q;
        error_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      retry_q     <= '0;
      redo_q      <= 1'b0;
      cnt_q       <= '0;
      rd_cap_q    <= '0;
      rd_seen_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      redo_q      <= redo_d;
      cnt_q       <= cnt_d;
      rd_cap_q    <= rd_cap_d;
      rd_seen_q   <= rd_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_index_q;
  assign dlpc_address  = addr_q;
  assign dlpc_wr_data  = wr_data_q;
  assign dlpc_wr_req   = wr_req_q;
  assign dlpc_rd_req   = rd_req_q;
  assign dlpc_rd_ready = 1'b1;

endmodule

// File: tb/tb_dlpc300_init_seq.sv
// Directed bench: instance A verifies read-back, instance B is write-only.
module tb_dlpc300_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic        start_a, busy_a, done_a, error_a, wr_req_a, rd_req_a, rd_valid_a, rd_ready_a, xfer_done_a;
  logic [7:0]  err_index_a, addr_a;
  logic [31:0] wr_data_a, rd_data_a;
  logic        start_b, busy_b, done_b, error_b, wr_req_b, rd_req_b, rd_valid_b, rd_ready_b, xfer_done_b;
  logic [7:0]  err_index_b, addr_b;
  logic [31:0] wr_data_b, rd_data_b;

  dlpc300_init_seq #(
    .N_ENTRIES(4), .PWR_DELAY(10), .GAP_CYCLES(20), .TIMEOUT_CYCLES(50), .MAX_RETRY(2), .VERIFY(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_index(err_index_a), .dlpc_address(addr_a), .dlpc_wr_req(wr_req_a), .dlpc_wr_data(wr_data_a),
    .dlpc_rd_req(rd_req_a), .dlpc_rd_data(rd_data_a), .dlpc_rd_valid(rd_valid_a),
    .dlpc_rd_ready(rd_ready_a), .xfer_done(xfer_done_a)
  );

  dlpc300_init_seq #(
    .N_ENTRIES(4), .PWR_DELAY(10), .GAP_CYCLES(20), .TIMEOUT_CYCLES(50), .MAX_RETRY(2), .VERIFY(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_index(err_index_b), .dlpc_address(addr_b), .dlpc_wr_req(wr_req_b), .dlpc_wr_data(wr_data_b),
    .dlpc_rd_req(rd_req_b), .dlpc_rd_data(rd_data_b), .dlpc_rd_valid(rd_valid_b),
    .dlpc_rd_ready(rd_ready_b), .xfer_done(xfer_done_b)
  );

  // Slave A: echoes writes; can drop a STOP for one address or corrupt read data.
  logic [31:0] mem_a [0:255];
  logic [7:0]  suppress_a = 8'hFF;
  logic [7:0]  corrupt_addr_a = 8'hFF;
  int          corrupt_left_a = 0;
  int          wr_n_a = 0, rd_n_a = 0, done_n_a = 0;
  logic        busy_at_done_a = 1'b1;
  logic [7:0]  wr_addr_log_a [0:63];
  logic [31:0] wr_data_log_a [0:63];
  logic [7:0]  rd_addr_log_a [0:63];

  initial begin
    int wcnt;
    int rcnt;
    logic [7:0] raddr;
    wcnt = 0; rcnt = 0; raddr = '0;
    xfer_done_a = 1'b0; rd_valid_a = 1'b0; rd_data_a = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
    forever begin
      @(posedge clk); #1;
      xfer_done_a = 1'b0;
      rd_valid_a  = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) xfer_done_a = 1'b1;
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 2) begin
          rd_valid_a = 1'b1;
          rd_data_a  = mem_a[raddr];
          if (raddr == corrupt_addr_a && corrupt_left_a > 0) begin
            rd_data_a = 32'hDEADBEEF;
            corrupt_left_a--;
          end
        end
        if (rcnt == 0) xfer_done_a = 1'b1;
      end
      if (wr_req_a) begin
        if (wr_n_a < 64) begin
          wr_addr_log_a[wr_n_a] = addr_a;
          wr_data_log_a[wr_n_a] = wr_data_a;
        end
        wr_n_a++;
        mem_a[addr_a] = wr_data_a;
        if (addr_a != suppress_a) wcnt = 4;
      end
      if (rd_req_a) begin
        if (rd_n_a < 64) rd_addr_log_a[rd_n_a] = addr_a;
        rd_n_a++;
        raddr = addr_a;
        rcnt  = 4;
      end
      if (done_a) begin
        done_n_a++;
        busy_at_done_a = busy_a;
      end
    end
  end

  // Slave B: write-only, logs request and STOP cycles.
  int          wr_n_b = 0, rd_n_b = 0, done_n_b = 0, xd_n_b = 0;
  int          wr_cyc_b [0:63];
  int          xd_cyc_b [0:63];
  logic [7:0]  wr_addr_log_b [0:63];

  initial begin
    int wcnt;
    wcnt = 0;
    xfer_done_b = 1'b0; rd_valid_b = 1'b0; rd_data_b = '0;
    forever begin
      @(posedge clk); #1;
      xfer_done_b = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          xfer_done_b = 1'b1;
          if (xd_n_b < 64) xd_cyc_b[xd_n_b] = cyc;
          xd_n_b++;
        end
      end
      if (wr_req_b) begin
        if (wr_n_b < 64) begin
          wr_cyc_b[wr_n_b]      = cyc;
          wr_addr_log_b[wr_n_b] = addr_b;
        end
        wr_n_b++;
        wcnt = 4;
      end
      if (rd_req_b) rd_n_b++;
      if (done_b) done_n_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_a();
    wr_n_a = 0; rd_n_a = 0; done_n_a = 0; busy_at_done_a = 1'b1;
  endtask

  task automatic wait_end_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_a || (error_a && !busy_a)) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  function automatic int wr_count_a(input logic [7:0] addr);
    int n;
    n = 0;
    for (int i = 0; i < wr_n_a && i < 64; i++)
      if (wr_addr_log_a[i] == addr) n++;
    return n;
  endfunction

  logic [7:0]  exp_addr [0:3];
  logic [31:0] exp_data [0:3];

  initial begin
    bit ok;
    int s, w;
    exp_addr[0] = 8'h00; exp_data[0] = 32'h0000_0001;
    exp_addr[1] = 8'h04; exp_data[1] = 32'h1234_5678;
    exp_addr[2] = 8'h08; exp_data[2] = 32'hA5A5_5A5A;
    exp_addr[3] = 8'h0C; exp_data[3] = 32'h0000_00FF;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_err_index", err_index_a, 0);
    check("rst_address", addr_a, 0);
    check("rst_wr_data", wr_data_a, 0);
    check("rst_wr_req", wr_req_a, 0);
    check("rst_rd_req", rd_req_a, 0);
    check("rst_rd_ready", rd_ready_a, 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Nominal run with read-back.
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("nom_busy_after_start", busy_a, 1);
    wait_end_a(3000, ok);
    check("nom_finished", ok, 1);
    check("nom_wr_count", wr_n_a, 4);
    check("nom_rd_count", rd_n_a, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nom_wr_addr%0d", i), wr_addr_log_a[i], exp_addr[i]);
      check($sformatf("nom_wr_data%0d", i), wr_data_log_a[i], exp_data[i]);
      check($sformatf("nom_rd_addr%0d", i), rd_addr_log_a[i], exp_addr[i]);
    end
    check("nom_done_count", done_n_a, 1);
    check("nom_busy_at_done", busy_at_done_a, 0);
    check("nom_error", error_a, 0);

    // Entry 2 never completes: one write plus two retries, then FAIL.
    clear_a();
    suppress_a = 8'h08;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_end_a(3000, ok);
    check("tmo_finished", ok, 1);
    check("tmo_wr_to_08", wr_count_a(8'h08), 3);
    check("tmo_wr_count", wr_n_a, 5);
    check("tmo_error", error_a, 1);
    check("tmo_err_index", err_index_a, 2);
    check("tmo_busy", busy_a, 0);
    check("tmo_done_count", done_n_a, 0);
    suppress_a = 8'hFF;

    // One corrupted read-back of entry 1 is recovered by a retry.
    clear_a();
    corrupt_addr_a = 8'h04; corrupt_left_a = 1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("mm1_error_cleared", error_a, 0);
    wait_end_a(3000, ok);
    check("mm1_finished", ok, 1);
    check("mm1_wr_to_04", wr_count_a(8'h04), 2);
    check("mm1_wr_count", wr_n_a, 5);
    check("mm1_done_count", done_n_a, 1);
    check("mm1_error", error_a, 0);

    // Persistent corruption of entry 1 exhausts the retries.
    clear_a();
    corrupt_left_a = 100;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_end_a(3000, ok);
    check("mmx_finished", ok, 1);
    check("mmx_wr_to_04", wr_count_a(8'h04), 3);
    check("mmx_error", error_a, 1);
    check("mmx_err_index", err_index_a, 1);
    check("mmx_done_count", done_n_a, 0);
    corrupt_left_a = 0; corrupt_addr_a = 8'hFF;

    // Asynchronous reset while waiting for the first write to complete.
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (wr_req_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("rmid_reached_write", ok, 1);
    check("rmid_busy_before", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_busy", busy_a, 0);
    check("rmid_wr_req", wr_req_a, 0);
    check("rmid_wr_data", wr_data_a, 0);
    check("rmid_address", addr_a, 0);
    check("rmid_error", error_a, 0);
    check("rmid_rd_ready", rd_ready_a, 1);
    repeat (8) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Restart: first request comes PWR_DELAY+2 idle cycles after the start cycle.
    clear_a();
    s = cyc;
    start_a = 1'b1; tick(); start_a = 1'b0;
    ok = 1'b0;
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (wr_req_a) begin
        ok = 1'b1;
        w = cyc;
        break;
      end
      tick();
    end
    check("rst2_first_write", ok, 1);
    check("rst2_pwr_latency", w - s - 1, 12);
    check("rst2_address", addr_a, 8'h00);
    wait_end_a(3000, ok);
    check("rst2_finished", ok, 1);
    check("rst2_done_count", done_n_a, 1);

    // Write-only instance; a second start mid-sequence must be ignored.
    start_b = 1'b1; tick(); start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (wr_n_b >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("wo_reached_entry1", ok, 1);
    start_b = 1'b1; tick(); start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
    check("wo_finished", ok, 1);
    check("wo_done_count", done_n_b, 1);
    check("wo_wr_count", wr_n_b, 4);
    check("wo_rd_count", rd_n_b, 0);
    check("wo_last_addr", wr_addr_log_b[3], 8'h0C);
    check("wo_gap_cycles", wr_cyc_b[1] - xd_cyc_b[0] - 1, 22);
    check("wo_busy", busy_b, 0);
    check("wo_error", error_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dlpc300_init_seq.md
Name: dlpc300_init_seq

Overview:
- Power-up configuration sequencer directly upstream of dlpc300_config_intf.
- Walks a fixed table of {register address, 32-bit data} entries and issues one write per entry on the dlpc_* request interface.
- Optionally reads each register back and compares it with the written value.
- Reports busy/done/error to the system controller and holds the DLPC300 config port idle otherwise.

Parameters:
- N_ENTRIES, 16: number of table entries walked, 1..256.
- PWR_DELAY, 100000: clk cycles waited after start before the first command.
- GAP_CYCLES, 1000: idle clk cycles between consecutive I2C transactions.
- TIMEOUT_CYCLES, 200000: max cycles waiting for transaction completion.
- MAX_RETRY, 2: re-issues of a timed-out or mismatched entry before failing.
- VERIFY, 1: 1 = read back and compare each entry; 0 = write only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins sequence from entry 0
- busy  out  1  high from accepted start until DONE/FAIL
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; set on FAIL, cleared by next accepted start
- err_index  out  8  entry index that failed, valid while error=1
- dlpc_address  out  8  register address to config intf
- dlpc_wr_req  out  1  one-cycle write request pulse
- dlpc_wr_data  out  32  write data
- dlpc_rd_req  out  1  one-cycle read request pulse
- dlpc_rd_data  in  32  read data from config intf
- dlpc_rd_valid  in  1  read data valid
- dlpc_rd_ready  out  1  read data accept
- xfer_done  in  1  one-cycle pulse at I2C STOP completion of current transaction

Behaviour:
- Reset: state IDLE; busy=0, done=0, error=0, err_index=0, dlpc_address=0, dlpc_wr_data=0, dlpc_wr_req=0, dlpc_rd_req=0, dlpc_rd_ready=1; all counters 0.
- States: IDLE, PWR_WAIT, FETCH, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, GAP, DONE, FAIL.
- IDLE: on start -> PWR_WAIT; busy=1, error=0, index=0, retry=0. start is ignored in every other state.
- PWR_WAIT: count PWR_DELAY cycles -> FETCH. PWR_DELAY=0 gives one cycle here.
- FETCH: register rom_addr(index); latch entry into dlpc_address/dlpc_wr_data one cycle later -> WR_REQ. Both outputs are held stable until the next FETCH.
- WR_REQ: dlpc_wr_req=1 for exactly one cycle -> WR_WAIT; clear the timeout counter.
- WR_WAIT: on xfer_done -> RD_REQ if VERIFY, else GAP. On timeout counter = TIMEOUT_CYCLES-1 -> retry path.
- RD_REQ: dlpc_rd_req=1 for one cycle -> RD_WAIT.
- RD_WAIT: capture dlpc_rd_data when dlpc_rd_valid & dlpc_rd_ready; complete on xfer_done -> CHECK. If xfer_done arrives without a prior valid, treat as mismatch. Timeout -> retry path.
- CHECK: captured data == dlpc_wr_data -> GAP; else retry path.
- Retry path: if retry < MAX_RETRY then retry++, -> GAP, and re-execute the same index. Else err_index=index, -> FAIL.
- GAP: count GAP_CYCLES. At the end, either re-execute the same index after a retry, or index++ with retry=0. If the completed index was N_ENTRIES-1 -> DONE, else -> FETCH.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- FAIL: error=1, busy=0 -> IDLE. error stays sticky.
- xfer_done outside WR_WAIT/RD_WAIT is ignored. A simultaneous xfer_done and timeout counts as success.
- Counters: 18-bit minimum; width = clog2 of max(PWR_DELAY, GAP_CYCLES, TIMEOUT_CYCLES)+1.
- Reset mid-operation returns immediately to the reset state. Request pulses never extend across reset.

Decomposition:
- Package dlpc300_pkg holds:
  - state enum encodings;
  - ENTRY_W=40, with entry layout [39:32] address and [31:0] data;
  - default table constants.
- Sub-module dlpc300_init_rom: synchronous-read ROM, input addr[7:0], output entry[39:0], case-statement contents, one-cycle latency. It is the only place the table lives.

Test Plan:
- Nominal, VERIFY=1, N_ENTRIES=4, PWR_DELAY=10, GAP_CYCLES=20, slave model echoes writes.
  - start -> 4 wr_req and 4 rd_req pulses, addresses 00,04,08,0C, each with the correct data.
  - done pulses once; busy falls in the same cycle; error=0.
- Gap timing: measure cycles from xfer_done to the next request -> exactly GAP_CYCLES+2 (GAP, FETCH, latch).
- Timeout: suppress xfer_done for entry 2, MAX_RETRY=2, TIMEOUT_CYCLES=50 -> 3 wr_req pulses to address 08, then error=1, err_index=2, busy=0, no done.
- Mismatch: slave returns 0xDEADBEEF once for entry 1 -> one retry, then success and done. Returning it always -> error=1, err_index=1.
- Reset mid-WR_WAIT -> all outputs at reset values within the asynchronous assert. A later start restarts at entry 0 after PWR_DELAY.
- VERIFY=0, start asserted while busy -> ignored; no rd_req pulses ever; done after N_ENTRIES writes.
